async_fifo_rd_ctrl: RTL and testbench

- Read-side controller for the team's asynchronous FIFO; runs entirely in the read clock domain.
- Synchronises the write pointer (Gray), converts it to binary with the team's gray-to-binary converter (SIZE = ADDR_W+1), and computes the fill level.
- Sequences a synchronous-read dual-port RAM into a first-word-fall-through valid/ready output.
- Returns its own read pointer in Gray code for the write domain's full logic.

---
 rtl/async_fifo_rd_ctrl.sv | 142 ++++++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: write-pointer sync,
// fill level, FWFT sequencing of a synchronous-read RAM, Gray read pointer.

module gray2bin #(
   parameter int SIZE = 5
) (
   input  logic [SIZE-1:0] gray_i,
   output logic [SIZE-1:0] bin_o
);

   always_comb begin
      bin_o = '0;
      for (int i = 0; i < SIZE; i++) begin
         bin_o[i] = ^(gray_i >> i);
      end
   end

endmodule

module async_fifo_rd_ctrl #(
   parameter int ADDR_W       = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W:0]   wr_ptr_gray_async,
   output logic [ADDR_W:0]   rd_ptr_gray,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   rd_level,
   output logic              ptr_err
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W+1:0] AE_TH = (ADDR_W+2)'(ALMOST_EMPTY);

   typedef enum logic {
      S_EMPTY,
      S_VALID
   } state_t;

   state_t          state_q, state_d;
   logic [ADDR_W:0] sync_q [SYNC_STAGES];
   logic [ADDR_W:0] wr_bin_s;
   logic [ADDR_W:0] rd_bin_q, rd_bin_d;
   logic [ADDR_W:0] rd_gray_q, rd_gray_d;
   logic            ptr_err_q, ptr_err_d;
   logic [ADDR_W:0] level;
   logic            lvl_over;
   logic            fetch_ok;
   logic [ADDR_W+1:0] avail;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= wr_ptr_gray_async;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   gray2bin #(
      .SIZE (ADDR_W+1)
   ) u_g2b (
      .gray_i (sync_q[SYNC_STAGES-1]),
      .bin_o  (wr_bin_s)
   );

   // Modulo difference; equal low bits with differing MSB is a legal full.
   assign level    = wr_bin_s - rd_bin_q;
   assign lvl_over = level > DEPTH;
   assign fetch_ok = (level != '0) && !ptr_err_q && !lvl_over;

   always_comb begin
      state_d   = state_q;
      mem_rd_en = 1'b0;
      rd_valid  = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (fetch_ok) begin
               mem_rd_en = 1'b1;
               state_d   = S_VALID;
            end
         end
         S_VALID: begin
            rd_valid = 1'b1;
            if (rd_ready) begin
               if (fetch_ok) begin
                  mem_rd_en = 1'b1;
               end else begin
                  state_d = S_EMPTY;
               end
            end
         end
      endcase
   end

   // The slot is handed back to the writer at fetch time.
   always_comb begin
      rd_bin_d  = rd_bin_q;
      rd_gray_d = rd_gray_q;
      if (mem_rd_en) begin
         rd_bin_d  = rd_bin_q + ONE;
         rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
      end
      ptr_err_d = ptr_err_q | lvl_over;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_EMPTY;
         rd_bin_q  <= '0;
         rd_gray_q <= '0;
         ptr_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_bin_q  <= rd_bin_d;
         rd_gray_q <= rd_gray_d;
         ptr_err_q <= ptr_err_d;
      end
   end

   assign avail = {1'b0, level} + {{(ADDR_W+1){1'b0}}, rd_valid};

   assign mem_rd_addr  = rd_bin_q[ADDR_W-1:0];
   assign rd_ptr_gray  = rd_gray_q;
   assign empty        = !rd_valid;
   assign almost_empty = avail <= AE_TH;
   assign rd_level     = level;
   assign ptr_err      = ptr_err_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: fetch-address scoreboard, level table,
// and hand-written latency / wrap / error / reset sequences.

module tb_async_fifo_rd_ctrl;

   logic       clk;
   logic       rst;
   logic [4:0] wr_ptr_gray_async;
   logic [4:0] rd_ptr_gray;
   logic       mem_rd_en;
   logic [3:0] mem_rd_addr;
   logic       rd_valid;
   logic       rd_ready;
   logic       empty;
   logic       almost_empty;
   logic [4:0] rd_level;
   logic       ptr_err;

   async_fifo_rd_ctrl #(
      .ADDR_W       (4),
      .SYNC_STAGES  (2),
      .ALMOST_EMPTY (2)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .wr_ptr_gray_async (wr_ptr_gray_async),
      .rd_ptr_gray       (rd_ptr_gray),
      .mem_rd_en         (mem_rd_en),
      .mem_rd_addr       (mem_rd_addr),
      .rd_valid          (rd_valid),
      .rd_ready          (rd_ready),
      .empty             (empty),
      .almost_empty      (almost_empty),
      .rd_level          (rd_level),
      .ptr_err           (ptr_err)
   );

   typedef struct {
      logic [4:0] wr;
      logic [4:0] lvl;
      logic       v;
      logic       ae;
      logic       err;
   } vec_t;

   vec_t       tbl [5];
   logic [3:0] exp_q [$];
   logic [4:0] wr_bin;
   logic [4:0] rd_model;
   int         n_chk;
   int         n_fail;
   int         n_hs;
   int         n_fetch;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] g(logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic advance(logic [4:0] nw);
      logic [4:0] p;
      p = wr_bin;
      while (p != nw) begin
         exp_q.push_back(p[3:0]);
         p++;
      end
      wr_bin            = nw;
      wr_ptr_gray_async = g(nw);
   endtask

   task automatic set_wr(logic [4:0] nw);
      wr_bin            = nw;
      wr_ptr_gray_async = g(nw);
   endtask

   task automatic do_reset(int n);
      rst = 1'b1;
      set_wr(5'd0);
      repeat (n) cyc();
      rst = 1'b0;
   endtask

   task automatic wait_drain(int bound);
      int k;
      k = 0;
      repeat (3) cyc();
      while (k < bound && (rd_valid || rd_level != 5'd0)) begin
         cyc();
         k++;
      end
      chk("drain_in_time", 32'(k < bound), 1);
      cyc();
   endtask

   // Scoreboard: every fetch must match the oldest written slot.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         rd_model = '0;
      end else begin
         chk("rd_ptr_gray", rd_ptr_gray, g(rd_model));
         chk("empty_vs_valid", empty, !rd_valid);
         if (rd_valid && rd_ready) n_hs++;
         if (mem_rd_en) begin
            n_fetch++;
            if (exp_q.size() == 0) begin
               chk("unexpected_fetch", mem_rd_en, 0);
            end else begin
               chk("fetch_addr", mem_rd_addr, exp_q.pop_front());
            end
            rd_model++;
         end
      end
   end

   initial begin
      tbl[0] = '{wr: 5'd1,  lvl: 5'd0,  v: 1'b1, ae: 1'b1, err: 1'b0};
      tbl[1] = '{wr: 5'd2,  lvl: 5'd1,  v: 1'b1, ae: 1'b1, err: 1'b0};
      tbl[2] = '{wr: 5'd3,  lvl: 5'd2,  v: 1'b1, ae: 1'b0, err: 1'b0};
      tbl[3] = '{wr: 5'd8,  lvl: 5'd7,  v: 1'b1, ae: 1'b0, err: 1'b0};
      tbl[4] = '{wr: 5'd17, lvl: 5'd16, v: 1'b1, ae: 1'b0, err: 1'b0};

      n_chk    = 0;
      n_fail   = 0;
      n_hs     = 0;
      n_fetch  = 0;
      rd_model = '0;
      rd_ready = 1'b0;
      rst      = 1'b1;
      set_wr(5'd0);

      do_reset(3);
      @(negedge clk);
      chk("rst_valid", rd_valid, 0);
      chk("rst_empty", empty, 1);
      chk("rst_gray", rd_ptr_gray, 0);
      chk("rst_level", rd_level, 0);
      chk("rst_err", ptr_err, 0);
      chk("rst_ae", almost_empty, 1);
      chk("rst_en", mem_rd_en, 0);

      // Single word: exact latency
      cyc();
      rd_ready = 1'b1;
      advance(5'd1);
      cyc();
      @(negedge clk);
      chk("sw_c1_level", rd_level, 0);
      chk("sw_c1_en", mem_rd_en, 0);
      cyc();
      @(negedge clk);
      chk("sw_c2_level", rd_level, 1);
      chk("sw_c2_en", mem_rd_en, 1);
      chk("sw_c2_addr", mem_rd_addr, 0);
      cyc();
      @(negedge clk);
      chk("sw_c3_valid", rd_valid, 1);
      cyc();
      @(negedge clk);
      chk("sw_c4_empty", empty, 1);
      chk("sw_c4_gray", rd_ptr_gray, 5'b00001);

      // Burst with backpressure
      cyc();
      do_reset(1);
      rd_ready = 1'b0;
      n_fetch  = 0;
      advance(5'd5);
      repeat (6) cyc();
      @(negedge clk);
      chk("bp_valid", rd_valid, 1);
      chk("bp_level", rd_level, 4);
      chk("bp_en", mem_rd_en, 0);
      chk("bp_fetches", n_fetch, 1);
      cyc();
      rd_ready = 1'b1;
      n_hs     = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b2b_en", mem_rd_en, 1);
         cyc();
      end
      wait_drain(20);
      chk("bp_handshakes", n_hs, 5);
      chk("bp_level_end", rd_level, 0);

      // Full and wrap: rd_bin to 28, then level = DEPTH
      advance(5'd20);
      wait_drain(40);
      advance(5'd28);
      wait_drain(40);
      rd_ready = 1'b0;
      advance(5'd12);
      repeat (6) cyc();
      @(negedge clk);
      chk("full_err", ptr_err, 0);
      chk("full_level", rd_level, 15);
      chk("full_valid", rd_valid, 1);
      cyc();
      rd_ready = 1'b1;
      n_hs     = 0;
      wait_drain(40);
      chk("wrap_handshakes", n_hs, 16);
      chk("wrap_gray", rd_ptr_gray, g(5'd12));
      chk("wrap_err", ptr_err, 0);

      // Level / almost_empty table under backpressure
      do_reset(2);
      rd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         advance(tbl[i].wr);
         repeat (4) cyc();
         @(negedge clk);
         chk("tbl_level", rd_level, tbl[i].lvl);
         chk("tbl_valid", rd_valid, tbl[i].v);
         chk("tbl_ae", almost_empty, tbl[i].ae);
         chk("tbl_err", ptr_err, tbl[i].err);
         cyc();
      end
      rd_ready = 1'b1;
      n_hs     = 0;
      wait_drain(60);
      chk("tbl_handshakes", n_hs, 17);

      // Reset mid-stream while holding a word
      rd_ready = 1'b0;
      advance(5'd20);
      repeat (5) cyc();
      @(negedge clk);
      chk("mid_valid_pre", rd_valid, 1);
      cyc();
      rst = 1'b1;
      set_wr(5'd0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_valid", rd_valid, 0);
      chk("mid_gray", rd_ptr_gray, 0);
      chk("mid_en", mem_rd_en, 0);

      // Pointer error: level 17 is sticky and blocks fetches
      cyc();
      n_fetch = 0;
      set_wr(5'd17);
      repeat (6) cyc();
      @(negedge clk);
      chk("perr_set", ptr_err, 1);
      chk("perr_valid", rd_valid, 0);
      chk("perr_en", mem_rd_en, 0);
      cyc();
      set_wr(5'd1);
      repeat (6) cyc();
      @(negedge clk);
      chk("perr_sticky", ptr_err, 1);
      chk("perr_level", rd_level, 1);
      chk("perr_valid2", rd_valid, 0);
      chk("perr_fetches", n_fetch, 0);
      cyc();
      do_reset(1);
      @(negedge clk);
      chk("perr_clear", ptr_err, 0);
      repeat (4) cyc();
      chk("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
